// File: rtl/dnn_accel_mem_read_streamer.sv
// Avalon-MM read master streaming COUNT words from BASE of the on-chip RAM.
// Ports: start/base_addr/word_count in, busy/done status, mem_* RAM port, out_* stream.
module dnn_accel_mem_read_streamer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OC_W  = $clog2(FIFO_DEPTH + READ_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [1:0]          state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [ADDR_W:0]     issue_rem_q;
  logic [ADDR_W:0]     total_q;
  logic [ADDR_W:0]     out_idx_q;
  logic                done_q;
  logic [READ_LAT-1:0] pipe_q;
  logic [READ_LAT-1:0] pipe_n;
  logic [DATA_W-1:0]   buf_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FC_W-1:0]     fifo_count_q;

  logic [OC_W-1:0] inflight;
  logic [OC_W-1:0] occ;
  logic idle;
  logic issue;
  logic arrive;
  logic fifo_empty;
  logic fire;
  logic push;
  logic pop;
  logic last_fire;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + OC_W'(pipe_q[i]);
    end
  end

  // Space check covers words already buffered and reads still in flight.
  assign occ   = OC_W'(fifo_count_q) + inflight;
  assign idle  = (state_q == S_IDLE);
  assign issue = (state_q == S_FETCH) &&
                 (issue_rem_q != '0) &&
                 (occ < OC_W'(FIFO_DEPTH));

  always_comb begin
    pipe_n    = pipe_q << 1;
    pipe_n[0] = issue;
  end

  assign arrive     = pipe_q[READ_LAT-1];
  assign fifo_empty = (fifo_count_q == '0);

  // Arriving data bypasses an empty FIFO so the first word shows up
  // the cycle it leaves the RAM.
  assign out_valid = !fifo_empty || arrive;
  assign out_data  = fifo_empty ? mem_readdata : buf_q[rd_ptr_q];
  assign fire      = out_valid && out_ready;
  assign pop       = fire && !fifo_empty;
  assign push      = arrive && !(fifo_empty && out_ready);
  assign out_last  = out_valid && (out_idx_q == total_q - CNT_ONE);
  assign last_fire = fire && out_last;

  assign busy           = !idle;
  assign done           = done_q;
  assign mem_address    = cur_addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_writedata  = '0;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      issue_rem_q <= '0;
      total_q     <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      pipe_q <= pipe_n;
      done_q <= (idle && start && (word_count == '0)) || last_fire;
      unique case (state_q)
        S_IDLE: begin
          if (start && (word_count != '0)) begin
            state_q     <= S_FETCH;
            cur_addr_q  <= base_addr;
            issue_rem_q <= word_count;
            total_q     <= word_count;
            out_idx_q   <= '0;
          end
        end
        S_FETCH: begin
          if (issue && (issue_rem_q == CNT_ONE)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_fire) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (issue) begin
        cur_addr_q  <= cur_addr_q + 1'b1;
        issue_rem_q <= issue_rem_q - CNT_ONE;
      end
      if (fire) begin
        out_idx_q <= out_idx_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_dnn_accel_mem_read_streamer.sv
// Randomized bench for dnn_accel_mem_read_streamer against a queue model.
// Drives a behavioural 1-cycle RAM, records the stream and checks each scenario.
module tb_dnn_accel_mem_read_streamer;

  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [12:0] base_addr = 0;
  logic [13:0] word_count = 0;
  logic        busy, done;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [31:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1;

  logic [31:0] ram [8192];
  logic [31:0] rd_q = 0;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_data[$];
  logic [31:0] exp_data[$];
  int          got_addr[$];
  int          exp_addr[$];
  logic        got_last[$];
  int          cs_k[$];
  int cs_over, stall_bad, busy_bad, done_cnt, done_k, first_v_k, last_acc_k;
  bit timeout;

  dnn_accel_mem_read_streamer dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chipselect) rd_q <= ram[mem_address];
  end
  assign mem_readdata = rd_q;

  task automatic fill_ram(input bit ident);
    for (int i = 0; i < 8192; i++) ram[i] = ident ? i : $urandom;
  endtask

  function automatic void build_model(input int base, input int cnt);
    exp_data.delete();
    exp_addr.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back((base + i) % 8192);
      exp_data.push_back(ram[(base + i) % 8192]);
    end
  endfunction

  // Runs one transfer and records what the DUT did. mode: 0 ready=1,
  // 1 ready pattern 1,0,0, 2 random ready. inj_k>0 pulses a second start.
  task automatic run_xfer(input int base, input int cnt, input int mode,
                          input int inj_k, input int inj_base,
                          input int inj_cnt, input int max_k);
    int k, issued, accepted;
    bit pv_stall;
    logic [31:0] pd;
    got_data.delete(); got_addr.delete(); got_last.delete(); cs_k.delete();
    cs_over = 0; stall_bad = 0; busy_bad = 0; done_cnt = 0;
    done_k = -1; first_v_k = -1; last_acc_k = -1; timeout = 0;
    issued = 0; accepted = 0; pv_stall = 0; pd = 0;
    @(negedge clk);
    start = 1; base_addr = 13'(base); word_count = 14'(cnt); out_ready = 1;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      start = (k == inj_k);
      if (start) begin
        base_addr = 13'(inj_base); word_count = 14'(inj_cnt);
      end
      case (mode)
        0: out_ready = 1;
        1: out_ready = ((k % 3) == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv_stall && (!out_valid || out_data !== pd)) stall_bad++;
      if (mem_chipselect) begin
        cs_k.push_back(k);
        got_addr.push_back(int'(mem_address));
        if (issued - accepted >= 4) cs_over++;
        issued++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        if (busy !== 1'b0) busy_bad++;
      end else if (cnt == 0 || done_k >= 0) begin
        if (busy !== 1'b0) busy_bad++;
      end else if (busy !== 1'b1) busy_bad++;
      if (out_valid && first_v_k < 0) first_v_k = k;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        accepted++;
        last_acc_k = k;
      end
      pv_stall = out_valid && !out_ready;
      pd = out_data;
      if (done_k >= 0 && k >= done_k + 2) break;
      if (k >= max_k) begin
        timeout = 1;
        break;
      end
    end
    start = 0;
    out_ready = 1;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #1;
    checks++;
    if ({busy, done, out_valid, out_last, mem_chipselect} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/last/cs=%b required 00000",
               {busy, done, out_valid, out_last, mem_chipselect});
    end
    checks++;
    if (mem_address !== 13'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d required 0", mem_address);
    end
    checks++;
    if ({mem_write, mem_byteenable, mem_clken} !== 6'b0_1111_1 || mem_writedata !== 32'd0) begin
      errors++;
      $display("FAIL tie_offs: write=%b be=%h clken=%b wdata=%h", mem_write,
               mem_byteenable, mem_clken, mem_writedata);
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_basic;
    fill_ram(1);
    build_model(0, 4);
    run_xfer(0, 4, 0, 0, 0, 0, 50);
    checks++;
    if (timeout || got_data != exp_data) begin
      errors++;
      $display("FAIL basic_data: got %p required %p timeout=%0d", got_data, exp_data, timeout);
    end
    checks++;
    if (got_last != '{1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_last: got %p required 0,0,0,1", got_last);
    end
    checks++;
    if (cs_k != '{1, 2, 3, 4} || got_addr != exp_addr) begin
      errors++;
      $display("FAIL basic_issue: cycles %p addrs %p required cycles 1..4 addrs 0..3", cs_k, got_addr);
    end
    checks++;
    if (first_v_k != 2 || last_acc_k != 5) begin
      errors++;
      $display("FAIL basic_latency: first valid %0d last accept %0d required 2 and 5",
               first_v_k, last_acc_k);
    end
    checks++;
    if (done_k != 6 || done_cnt != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL basic_done: done at %0d count %0d busy errs %0d required 6,1,0",
               done_k, done_cnt, busy_bad);
    end
  endtask

  task automatic test_wrap;
    fill_ram(0);
    build_model(8190, 4);
    run_xfer(8190, 4, 0, 0, 0, 0, 50);
    checks++;
    if (got_addr != '{8190, 8191, 0, 1}) begin
      errors++;
      $display("FAIL wrap_addr: got %p required 8190,8191,0,1", got_addr);
    end
    checks++;
    if (timeout || got_data != exp_data) begin
      errors++;
      $display("FAIL wrap_data: got %p required %p", got_data, exp_data);
    end
  endtask

  task automatic test_backpressure;
    fill_ram(0);
    build_model(500, 6);
    run_xfer(500, 6, 1, 0, 0, 0, 100);
    checks++;
    if (timeout || got_data != exp_data) begin
      errors++;
      $display("FAIL bp_data: got %p required %p", got_data, exp_data);
    end
    checks++;
    if (cs_over != 0) begin
      errors++;
      $display("FAIL bp_space: %0d issues with 4 outstanding, required 0", cs_over);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d stall cycles changed data, required 0", stall_bad);
    end
    checks++;
    if (got_last.size() != 6 || got_last[5] !== 1'b1 || got_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_last: got %p required last only on word 6", got_last);
    end
  endtask

  task automatic test_zero_count;
    run_xfer(77, 0, 0, 0, 0, 0, 20);
    checks++;
    if (got_addr.size() != 0 || got_data.size() != 0) begin
      errors++;
      $display("FAIL zero_activity: %0d issues %0d words required 0,0",
               got_addr.size(), got_data.size());
    end
    checks++;
    if (done_k != 1 || done_cnt != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL zero_done: done at %0d count %0d busy errs %0d required 1,1,0",
               done_k, done_cnt, busy_bad);
    end
  endtask

  task automatic test_restart_ignored;
    fill_ram(0);
    build_model(1234, 5);
    run_xfer(1234, 5, 0, 2, 4000, 3, 50);
    checks++;
    if (timeout || got_data != exp_data || got_addr != exp_addr) begin
      errors++;
      $display("FAIL restart_stream: addrs %p data %p required addrs %p",
               got_addr, got_data, exp_addr);
    end
    checks++;
    if (done_cnt != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL restart_done: done count %0d busy errs %0d required 1,0",
               done_cnt, busy_bad);
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    fill_ram(0);
    @(negedge clk);
    start = 1; base_addr = 13'd100; word_count = 14'd8; out_ready = 0;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({busy, done, out_valid, out_last, mem_chipselect} !== 5'b0 || mem_address !== 13'd0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b addr=%0d required 00000 and 0",
               {busy, done, out_valid, out_last, mem_chipselect}, mem_address);
    end
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || mem_chipselect || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midreset_discard: %0d cycles with activity, required 0", stray);
    end
    build_model(10, 2);
    run_xfer(10, 2, 0, 0, 0, 0, 30);
    checks++;
    if (timeout || got_data != exp_data) begin
      errors++;
      $display("FAIL midreset_restart: got %p required %p", got_data, exp_data);
    end
  endtask

  task automatic test_random;
    int base, cnt;
    for (int t = 0; t < 8; t++) begin
      fill_ram(0);
      base = $urandom_range(0, 8191);
      cnt = (t == 0) ? 1 : $urandom_range(1, 24);
      build_model(base, cnt);
      run_xfer(base, cnt, 2, 0, 0, 0, 400);
      checks++;
      if (timeout || got_data != exp_data || got_addr != exp_addr) begin
        errors++;
        $display("FAIL rand_stream[%0d]: base %0d cnt %0d got %0d words required %0d",
                 t, base, cnt, got_data.size(), cnt);
      end
      checks++;
      if (cs_over != 0 || stall_bad != 0 || busy_bad != 0 || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_rules[%0d]: over %0d stall %0d busy %0d done %0d required 0,0,0,1",
                 t, cs_over, stall_bad, busy_bad, done_cnt);
      end
      checks++;
      if (got_last.size() != cnt || got_last[cnt-1] !== 1'b1 ||
          (cnt > 1 && got_last[0] !== 1'b0)) begin
        errors++;
        $display("FAIL rand_last[%0d]: got %p required last only on word %0d", t, got_last, cnt);
      end
    end
  endtask

  task automatic test_full_ram;
    int nlast;
    int base;
    fill_ram(0);
    base = $urandom_range(0, 8191);
    build_model(base, 8192);
    run_xfer(base, 8192, 0, 0, 0, 0, 8400);
    checks++;
    if (timeout || got_addr != exp_addr || got_data != exp_data) begin
      errors++;
      $display("FAIL full_stream: base %0d got %0d words %0d issues required 8192 each",
               base, got_data.size(), got_addr.size());
    end
    nlast = 0;
    foreach (got_last[i]) if (got_last[i]) nlast++;
    checks++;
    if (nlast != 1 || got_last.size() != 8192 || got_last[8191] !== 1'b1) begin
      errors++;
      $display("FAIL full_last: %0d last flags, required exactly one on word 8192", nlast);
    end
    checks++;
    if (last_acc_k != 8193 || done_k != 8194) begin
      errors++;
      $display("FAIL full_rate: last accept %0d done %0d required 8193 and 8194",
               last_acc_k, done_k);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_count;
    test_restart_ignored;
    test_reset_mid;
    test_random;
    test_full_ram;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
